// File: rtl/hbmc_level_filter.sv
// -----------------------------------------------------------------------------
// hbmc_level_filter
//
// Purpose:
//   Deglitches a single already-synchronized status bit (e.g. HyperRAM INT# or
//   RSTO#) with a persistence counter. The filtered level changes only after
//   the input has differed from it for C_FILTER_CYCLES consecutive clocks.
//   The block also produces registered one-cycle rise/fall pulses, a sticky
//   event flag with synchronous clear, and a saturating 16-bit event counter
//   that feed a status register.
//
// Parameters:
//   C_FILTER_CYCLES  consecutive differing cycles before level follows (1..255)
//   C_RESET_STATE    reset value of level; matches the upstream synchronizer
//   C_EDGE_SEL       edges that count: [0] = rise, [1] = fall
//
// Ports:
//   arst        in   asynchronous reset, active-high
//   clk         in   clock
//   d_sync      in   synchronized input bit
//   clr         in   synchronous clear of event_flag / event_cnt
//   level       out  filtered level
//   rise        out  one-cycle pulse when level goes 0->1
//   fall        out  one-cycle pulse when level goes 1->0
//   event_flag  out  sticky flag, set on a selected edge
//   event_cnt   out  saturating count of selected edges
// -----------------------------------------------------------------------------
module hbmc_level_filter #(
    parameter int unsigned C_FILTER_CYCLES = 4,
    parameter logic        C_RESET_STATE   = 1'b0,
    parameter logic [1:0]  C_EDGE_SEL      = 2'b01
) (
    input  logic        arst,
    input  logic        clk,
    input  logic        d_sync,
    input  logic        clr,
    output logic        level,
    output logic        rise,
    output logic        fall,
    output logic        event_flag,
    output logic [15:0] event_cnt
);

    // Terminal count of the persistence counter: reaching it with the input
    // still differing means the new value has persisted long enough.
    localparam logic [7:0]  LP_LAST    = 8'(C_FILTER_CYCLES - 1);
    localparam logic [15:0] LP_CNT_MAX = 16'hFFFF;

    logic        r_level;
    logic        r_rise;
    logic        r_fall;
    logic [7:0]  r_persist;
    logic        r_event_flag;
    logic [15:0] r_event_cnt;

    logic        w_differs;
    logic        w_expire;
    logic        w_sel_evt;
    logic        w_cnt_sat;

    assign w_differs = (d_sync != r_level);
    assign w_expire  = w_differs && (r_persist == LP_LAST);

    // -------------------------------------------------------------------------
    // Persistence filter and edge pulses
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent logic.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_level   <= C_RESET_STATE;
            r_rise    <= 1'b0;
            r_fall    <= 1'b0;
            r_persist <= 8'd0;
        end else begin
            // Pulses are single-cycle: cleared by default, set only on the
            // edge where level actually changes.
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (!w_differs) begin
                // Any cycle that agrees with level restarts the count, so a
                // glitch shorter than C_FILTER_CYCLES is fully forgotten.
                r_persist <= 8'd0;
            end else if (w_expire) begin
                r_level   <= d_sync;
                r_persist <= 8'd0;
                r_rise    <= d_sync;
                r_fall    <= ~d_sync;
            end else begin
                r_persist <= r_persist + 8'd1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Event flag and counter, driven from the registered pulses so they trail
    // the pulse by one cycle.
    // -------------------------------------------------------------------------
    assign w_sel_evt = (r_rise & C_EDGE_SEL[0]) | (r_fall & C_EDGE_SEL[1]);
    assign w_cnt_sat = (r_event_cnt == LP_CNT_MAX);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_event_flag <= 1'b0;
            r_event_cnt  <= 16'h0000;
        end else begin
            // A coincident event beats clr so no edge is ever lost.
            if (w_sel_evt) begin
                r_event_flag <= 1'b1;
            end else if (clr) begin
                r_event_flag <= 1'b0;
            end

            if (clr) begin
                r_event_cnt <= w_sel_evt ? 16'h0001 : 16'h0000;
            end else if (w_sel_evt && !w_cnt_sat) begin
                r_event_cnt <= r_event_cnt + 16'h0001;
            end
        end
    end

    assign level      = r_level;
    assign rise       = r_rise;
    assign fall       = r_fall;
    assign event_flag = r_event_flag;
    assign event_cnt  = r_event_cnt;

    // -------------------------------------------------------------------------
    // Structural invariants
    // -------------------------------------------------------------------------
    a_no_dual_pulse : assert property (@(posedge clk) disable iff (arst)
        !(r_rise && r_fall));

    a_rise_one_cycle : assert property (@(posedge clk) disable iff (arst)
        r_rise |=> !r_rise);

    a_fall_one_cycle : assert property (@(posedge clk) disable iff (arst)
        r_fall |=> !r_fall);

    a_persist_bound : assert property (@(posedge clk) disable iff (arst)
        r_persist <= LP_LAST);

endmodule

// File: tb/tb_hbmc_level_filter.sv
// -----------------------------------------------------------------------------
// tb_hbmc_level_filter
//
// Three instances share clk/arst:
//   dut_a : 4-cycle filter, rise edges counted
//   dut_b : 4-cycle filter, both edges counted (same d_sync/clr as dut_a)
//   dut_c : 1-cycle filter, both edges counted, used for counter saturation
// -----------------------------------------------------------------------------
module tb_hbmc_level_filter;

    logic        clk;
    logic        arst;
    logic        d_sync;
    logic        clr;
    logic        d_c;
    logic        clr_c;

    logic        level_a, rise_a, fall_a, flag_a;
    logic [15:0] cnt_a;
    logic        level_b, rise_b, fall_b, flag_b;
    logic [15:0] cnt_b;
    logic        level_c, rise_c, fall_c, flag_c;
    logic [15:0] cnt_c;

    int n_checks = 0;
    int n_errors = 0;

    hbmc_level_filter #(.C_FILTER_CYCLES(4), .C_RESET_STATE(1'b0), .C_EDGE_SEL(2'b01)) dut_a (
        .arst(arst), .clk(clk), .d_sync(d_sync), .clr(clr),
        .level(level_a), .rise(rise_a), .fall(fall_a),
        .event_flag(flag_a), .event_cnt(cnt_a)
    );

    hbmc_level_filter #(.C_FILTER_CYCLES(4), .C_RESET_STATE(1'b0), .C_EDGE_SEL(2'b11)) dut_b (
        .arst(arst), .clk(clk), .d_sync(d_sync), .clr(clr),
        .level(level_b), .rise(rise_b), .fall(fall_b),
        .event_flag(flag_b), .event_cnt(cnt_b)
    );

    hbmc_level_filter #(.C_FILTER_CYCLES(1), .C_RESET_STATE(1'b0), .C_EDGE_SEL(2'b11)) dut_c (
        .arst(arst), .clk(clk), .d_sync(d_c), .clr(clr_c),
        .level(level_c), .rise(rise_c), .fall(fall_c),
        .event_flag(flag_c), .event_cnt(cnt_c)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        d;
        logic        clr;
        logic        level;
        logic        rise;
        logic        fall;
        logic        flag_a;
        logic [15:0] cnt_a;
        logic [15:0] cnt_b;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic d, input logic c, input logic lv, input logic r,
                       input logic f, input logic fa, input logic [15:0] ca,
                       input logic [15:0] cb);
        vec_t v;
        v.d = d; v.clr = c; v.level = lv; v.rise = r; v.fall = f;
        v.flag_a = fa; v.cnt_a = ca; v.cnt_b = cb;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks dut_a level/rise/fall against expectations.
    task automatic check_lrf(input string tag, input logic lv, input logic r, input logic f);
        check({tag, " level"}, {31'd0, level_a}, {31'd0, lv});
        check({tag, " rise"},  {31'd0, rise_a},  {31'd0, r});
        check({tag, " fall"},  {31'd0, fall_a},  {31'd0, f});
    endtask

    initial begin
        // Row n: inputs driven before edge n after reset release, outputs after it.
        // Reset release with d_sync=1 already pending (test 1).
        add(1,0, 0,0,0, 0,16'd0,16'd0);
        add(1,0, 0,0,0, 0,16'd0,16'd0);
        add(1,0, 0,0,0, 0,16'd0,16'd0);
        add(1,0, 1,1,0, 0,16'd0,16'd0);   // 4th edge: level rises
        add(1,0, 1,0,0, 1,16'd1,16'd1);   // flag/cnt one cycle later
        // Return to 0 so glitch test starts from level 0.
        add(0,0, 1,0,0, 1,16'd1,16'd1);
        add(0,0, 1,0,0, 1,16'd1,16'd1);
        add(0,0, 1,0,0, 1,16'd1,16'd1);
        add(0,0, 0,0,1, 1,16'd1,16'd1);
        add(0,0, 0,0,0, 1,16'd1,16'd2);   // fall counted only by dut_b
        // Clear (no pending event) while a 3-cycle glitch begins (test 2).
        add(1,1, 0,0,0, 0,16'd0,16'd0);
        add(1,0, 0,0,0, 0,16'd0,16'd0);
        add(1,0, 0,0,0, 0,16'd0,16'd0);
        add(0,0, 0,0,0, 0,16'd0,16'd0);   // glitch rejected, count restarts
        add(0,0, 0,0,0, 0,16'd0,16'd0);
        // 4-cycle pulse passes.
        add(1,0, 0,0,0, 0,16'd0,16'd0);
        add(1,0, 0,0,0, 0,16'd0,16'd0);
        add(1,0, 0,0,0, 0,16'd0,16'd0);
        add(1,0, 1,1,0, 0,16'd0,16'd0);
        add(0,0, 1,0,0, 1,16'd1,16'd1);
        add(0,0, 1,0,0, 1,16'd1,16'd1);
        add(0,0, 1,0,0, 1,16'd1,16'd1);
        add(0,0, 0,0,1, 1,16'd1,16'd1);   // fall on 4th edge sampling 0
        add(0,0, 0,0,0, 1,16'd1,16'd2);   // rise-only count stays 1
        add(0,1, 0,0,0, 0,16'd0,16'd0);   // clear before both-edge test

        arst   = 1'b1;
        d_sync = 1'b1;
        clr    = 1'b0;
        d_c    = 1'b0;
        clr_c  = 1'b0;

        // ---------------- Test 1: reset state ----------------
        #1;
        check("reset immediate level", {31'd0, level_a}, 32'd0);
        tick();
        tick();
        check_lrf("in reset", 1'b0, 1'b0, 1'b0);
        check("in reset flag", {31'd0, flag_a}, 32'd0);
        check("in reset cnt", {16'd0, cnt_a}, 32'd0);
        arst = 1'b0;

        // ---------------- Table: tests 1 and 2 ----------------
        for (int i = 0; i < tbl.size(); i++) begin
            d_sync = tbl[i].d;
            clr    = tbl[i].clr;
            tick();
            check_lrf($sformatf("row%0d", i), tbl[i].level, tbl[i].rise, tbl[i].fall);
            check($sformatf("row%0d flag_a", i), {31'd0, flag_a}, {31'd0, tbl[i].flag_a});
            check($sformatf("row%0d cnt_a", i),  {16'd0, cnt_a},  {16'd0, tbl[i].cnt_a});
            check($sformatf("row%0d cnt_b", i),  {16'd0, cnt_b},  {16'd0, tbl[i].cnt_b});
        end
        clr = 1'b0;

        // ---------------- Test 3: six edges, both-edge counting ----------------
        for (int t = 0; t < 3; t++) begin
            d_sync = 1'b1;
            for (int k = 1; k <= 4; k++) begin
                tick();
                check_lrf($sformatf("t3 up%0d.%0d", t, k), (k == 4), (k == 4), 1'b0);
            end
            d_sync = 1'b0;
            for (int k = 1; k <= 4; k++) begin
                tick();
                check_lrf($sformatf("t3 dn%0d.%0d", t, k), (k != 4), 1'b0, (k == 4));
            end
        end
        tick();
        check("t3 cnt_b before clr",  {16'd0, cnt_b}, 32'd6);
        check("t3 flag_b before clr", {31'd0, flag_b}, 32'd1);
        check("t3 cnt_a before clr",  {16'd0, cnt_a}, 32'd3);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("t3 cnt_b after clr",  {16'd0, cnt_b}, 32'd0);
        check("t3 flag_b after clr", {31'd0, flag_b}, 32'd0);
        check("t3 flag_a after clr", {31'd0, flag_a}, 32'd0);
        tick();
        check("t3 level unaffected", {31'd0, level_a}, 32'd0);

        // ---------------- Test 4: clr coincident with event ----------------
        d_sync = 1'b1;
        repeat (4) tick();
        d_sync = 1'b0;
        repeat (4) tick();
        d_sync = 1'b1;
        repeat (4) tick();
        check("t4 rise pulse", {31'd0, rise_a}, 32'd1);
        check("t4 cnt_a pre", {16'd0, cnt_a}, 32'd1);
        check("t4 cnt_b pre", {16'd0, cnt_b}, 32'd2);
        clr = 1'b1;               // sel_evt is high at this next edge
        tick();
        clr = 1'b0;
        check("t4 flag_a", {31'd0, flag_a}, 32'd1);
        check("t4 cnt_a",  {16'd0, cnt_a}, 32'd1);
        check("t4 flag_b", {31'd0, flag_b}, 32'd1);
        check("t4 cnt_b",  {16'd0, cnt_b}, 32'd1);

        // ---------------- Test 6: async reset mid-operation ----------------
        d_sync = 1'b0;
        repeat (4) tick();
        check("t6 level low", {31'd0, level_a}, 32'd0);
        d_sync = 1'b1;
        tick();
        tick();                   // persistence counter now 2
        #3;
        arst = 1'b1;
        #1;
        check_lrf("t6 mid-count reset", 1'b0, 1'b0, 1'b0);
        check("t6 mid-count flag", {31'd0, flag_a}, 32'd0);
        check("t6 mid-count cnt",  {16'd0, cnt_a}, 32'd0);
        check("t6 mid-count cnt_b", {16'd0, cnt_b}, 32'd0);
        tick();
        arst = 1'b0;
        // Counter must restart from 0: level rises on the 4th edge, not sooner.
        for (int k = 1; k <= 4; k++) begin
            tick();
            check_lrf($sformatf("t6 restart%0d", k), (k == 4), (k == 4), 1'b0);
        end
        #2;
        arst = 1'b1;              // during the rise pulse
        #1;
        check_lrf("t6 mid-pulse reset", 1'b0, 1'b0, 1'b0);
        d_sync = 1'b0;
        tick();
        arst = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check_lrf($sformatf("t6 quiet%0d", k), 1'b0, 1'b0, 1'b0);
            check($sformatf("t6 quiet%0d flag", k), {31'd0, flag_a}, 32'd0);
        end

        // ---------------- Test 5: saturation on dut_c ----------------
        check("t5 start cnt", {16'd0, cnt_c}, 32'd0);
        for (int k = 1; k <= 65540; k++) begin
            d_c = ~d_c;
            tick();
            if (k == 1) begin
                check("t5 one-cycle latency level", {31'd0, level_c}, 32'd1);
                check("t5 one-cycle latency rise",  {31'd0, rise_c},  32'd1);
            end
            if (k == 2) begin
                check("t5 fall pulse", {31'd0, fall_c}, 32'd1);
                check("t5 cnt after 2", {16'd0, cnt_c}, 32'd1);
            end
            if (k == 65535) check("t5 cnt FFFE", {16'd0, cnt_c}, 32'h0000FFFE);
            if (k == 65536) check("t5 cnt FFFF", {16'd0, cnt_c}, 32'h0000FFFF);
            if (k == 65537) check("t5 no wrap",  {16'd0, cnt_c}, 32'h0000FFFF);
        end
        check("t5 saturated", {16'd0, cnt_c}, 32'h0000FFFF);
        check("t5 flag",      {31'd0, flag_c}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
